// File: rtl/register_ops_nb_pkg.sv
// Shared op-code encodings for the N-bit register with load/inc/dec/shift/rotate ops.
// OP_W is the op-select width used by the top and by the next-state logic.
package register_ops_nb_pkg;
   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 3'd0,
      OP_LOAD = 3'd1,
      OP_INC  = 3'd2,
      OP_DEC  = 3'd3,
      OP_ASL  = 3'd4,
      OP_LSR  = 3'd5,
      OP_ROL  = 3'd6,
      OP_ROR  = 3'd7
   } op_e;
endpackage

// File: rtl/register_ops_nb_next.sv
// Combinational next-state logic: new value, carry and Z/N for the selected op.
// Arithmetic wraps at WIDTH bits; carry passes through unless a shift or rotate drives it.
module register_ops_next_nb
   import register_ops_nb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             c_in,
   input  logic [OP_W-1:0]  op,
   input  logic             c,
   output logic [WIDTH-1:0] next_q,
   output logic             next_c,
   output logic             next_z,
   output logic             next_n
);

   always_comb begin
      next_q = q;
      next_c = c;
      case (op_e'(op))
         OP_LOAD: next_q = d;
         OP_INC:  next_q = q + WIDTH'(1);
         OP_DEC:  next_q = q - WIDTH'(1);
         OP_ASL: begin
            next_c = q[WIDTH-1];
            next_q = {q[WIDTH-2:0], 1'b0};
         end
         OP_LSR: begin
            next_c = q[0];
            next_q = {1'b0, q[WIDTH-1:1]};
         end
         OP_ROL: begin
            next_c = q[WIDTH-1];
            next_q = {q[WIDTH-2:0], c_in};
         end
         OP_ROR: begin
            next_c = q[0];
            next_q = {c_in, q[WIDTH-1:1]};
         end
         default: ;
      endcase
   end

   assign next_z = (next_q == '0);
   assign next_n = next_q[WIDTH-1];

endmodule

// File: rtl/register_ops_nb.sv
// Clocked N-bit register with op-selected update and 6502-style Z/N/C flags.
// Holds only the flops and the reset > clear > enable priority; next values come from the sub-module.
module register_ops_nb
   import register_ops_nb_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             en,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] d,
   input  logic             c_in,
   output logic [WIDTH-1:0] q,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c
);

   logic [WIDTH-1:0] next_q;
   logic             next_c;
   logic             next_z;
   logic             next_n;

   register_ops_next_nb #(
      .WIDTH (WIDTH)
   ) u_next (
      .q      (q),
      .d      (d),
      .c_in   (c_in),
      .op     (op),
      .c      (flag_c),
      .next_q (next_q),
      .next_c (next_c),
      .next_z (next_z),
      .next_n (next_n)
   );

   // NOP is treated as a hold so the flags are not rewritten.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q      <= RESET_VALUE;
         flag_z <= (RESET_VALUE == '0);
         flag_n <= RESET_VALUE[WIDTH-1];
         flag_c <= 1'b0;
      end else if (clear) begin
         q      <= '0;
         flag_z <= 1'b1;
         flag_n <= 1'b0;
      end else if (en && (op_e'(op) != OP_NOP)) begin
         q      <= next_q;
         flag_z <= next_z;
         flag_n <= next_n;
         flag_c <= next_c;
      end
   end

endmodule

// File: tb/tb_register_ops_nb.sv
// Scoreboard bench for register_ops_nb: directed cases then random ops against an arithmetic model.
// Two instances share stimulus: RESET_VALUE=0 (scoreboarded) and RESET_VALUE=FF (reset checks).
module tb_register_ops_nb;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clear = 1'b0;
   logic       en = 1'b0;
   logic [2:0] op = 3'd0;
   logic [7:0] d = 8'h00;
   logic       c_in = 1'b0;
   logic [7:0] q0, q1;
   logic       z0, n0, c0, z1, n1, c1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [10:0] v;
      string       nm;
   } exp_t;
   exp_t sb[$];

   int m_q = 0;
   int m_c = 0;

   always #5 clk = ~clk;

   register_ops_nb #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .op(op), .d(d), .c_in(c_in),
      .q(q0), .flag_z(z0), .flag_n(n0), .flag_c(c0)
   );

   register_ops_nb #(.WIDTH(8), .RESET_VALUE(8'hFF)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .op(op), .d(d), .c_in(c_in),
      .q(q1), .flag_z(z1), .flag_n(n1), .flag_c(c1)
   );

   task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got q=%h z=%b n=%b c=%b, want q=%h z=%b n=%b c=%b",
                  nm, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
      end
   endtask

   function automatic logic [10:0] model_word();
      logic [7:0] mq;
      mq = m_q[7:0];
      return {mq, (m_q == 0), (m_q >= 128), (m_c != 0)};
   endfunction

   // Drive one cycle of inputs at the falling edge and queue the value expected after the next rising edge.
   task automatic step(input bit rn, input bit clr, input bit e, input int o, input int dv,
                       input bit ci, input string nm);
      exp_t x;
      @(negedge clk);
      reset_n = rn;
      clear   = clr;
      en      = e;
      op      = o[2:0];
      d       = dv[7:0];
      c_in    = ci;
      if (!rn) begin
         m_q = 0;
         m_c = 0;
      end else if (clr) begin
         m_q = 0;
      end else if (e) begin
         case (o)
            1: m_q = dv % 256;
            2: m_q = (m_q + 1) % 256;
            3: m_q = (m_q + 255) % 256;
            4: begin m_c = m_q / 128; m_q = (m_q * 2) % 256; end
            5: begin m_c = m_q % 2;   m_q = m_q / 2; end
            6: begin m_c = m_q / 128; m_q = (m_q * 2) % 256 + int'(ci); end
            7: begin m_c = m_q % 2;   m_q = m_q / 2 + 128 * int'(ci); end
            default: ;
         endcase
      end
      x.v  = model_word();
      x.nm = nm;
      sb.push_back(x);
   endtask

   // Monitor: one registered result per rising edge, compared just after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.nm, {q0, z0, n0, c0}, x.v);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rv00", {q0, z0, n0, c0}, {8'h00, 1'b1, 1'b0, 1'b0});
      chk("reset_rvff", {q1, z1, n1, c1}, {8'hFF, 1'b0, 1'b1, 1'b0});

      step(1, 0, 1, 1, 8'h80, 0, "load80");
      step(1, 0, 0, 1, 8'h11, 0, "hold1");
      step(1, 0, 0, 2, 8'h11, 1, "hold2");
      step(1, 0, 0, 7, 8'h11, 1, "hold3");
      step(1, 0, 1, 1, 8'hFF, 0, "loadff");
      step(1, 0, 1, 2, 8'h00, 0, "inc_wrap");
      step(1, 0, 1, 3, 8'h00, 0, "dec_wrap");
      step(1, 0, 1, 1, 8'h81, 0, "load81");
      step(1, 0, 1, 4, 8'h00, 0, "asl");
      step(1, 0, 1, 7, 8'h00, 1, "ror_cin1");
      step(1, 0, 1, 5, 8'h00, 0, "lsr");
      step(1, 1, 1, 1, 8'h55, 0, "clear_prio");
      step(1, 0, 1, 0, 8'h99, 1, "nop");
      step(1, 0, 1, 6, 8'h00, 1, "rol_cin1");
      step(1, 0, 1, 1, 8'h42, 0, "load42");

      // Reset pulled low between edges must act before the next rising edge.
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_now", {q0, z0, n0, c0}, {8'h00, 1'b1, 1'b0, 1'b0});
      chk("async_reset_rvff", {q1, z1, n1, c1}, {8'hFF, 1'b0, 1'b1, 1'b0});
      m_q = 0;
      m_c = 0;
      step(0, 0, 1, 1, 8'h33, 0, "reset_held1");
      step(0, 0, 1, 2, 8'h33, 0, "reset_held2");
      step(1, 0, 1, 1, 8'h07, 0, "load07_after_release");

      for (int i = 0; i < 400; i++) begin
         step(1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
              bit'($urandom_range(0, 1)), "random");
      end

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
